// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto a single valid/ready memory channel, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin grant; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err,
    output logic                resp_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state;
    logic                owner_lsu;
    logic                req_valid;
    logic                req_wen;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wmask;
    logic                grant_ifu;
    logic                grant_lsu;
    logic                grant_open;
    logic                resp_hit;

    // Reset is folded in so neither ready can rise while the block is held in reset.
    assign grant_open = (state == IDLE) && reset;

`ifdef MEM_ARB_RR_EN
    logic last_owner_lsu;

    always_comb begin
        grant_lsu = 1'b0;
        grant_ifu = 1'b0;
        if (grant_open) begin
            if (lsu_req_valid && ifu_req_valid) begin
                grant_lsu = ~last_owner_lsu;
                grant_ifu = last_owner_lsu;
            end else begin
                grant_lsu = lsu_req_valid;
                grant_ifu = ifu_req_valid;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_owner_lsu <= 1'b1;
        end else if (grant_lsu || grant_ifu) begin
            last_owner_lsu <= grant_lsu;
        end
    end
`else
    always_comb begin
        grant_lsu = grant_open && lsu_req_valid;
        grant_ifu = grant_open && ifu_req_valid && !lsu_req_valid;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            req_valid <= 1'b0;
            req_wen   <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        owner_lsu <= 1'b1;
                        req_valid <= 1'b1;
                        req_wen   <= lsu_wen;
                        req_addr  <= lsu_addr;
                        req_wdata <= lsu_wdata;
                        req_wmask <= lsu_wmask;
                        state     <= REQ;
                    end else if (grant_ifu) begin
                        owner_lsu <= 1'b0;
                        req_valid <= 1'b1;
                        req_wen   <= 1'b0;
                        req_addr  <= ifu_addr;
                        req_wdata <= '0;
                        req_wmask <= '1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        req_valid <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    req_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Responses are only honoured while waiting for one; stray beats elsewhere are dropped.
    assign resp_hit       = (state == RESP) && mem_resp_valid;
    assign ifu_resp_valid = resp_hit && !owner_lsu;
    assign lsu_resp_valid = resp_hit && owner_lsu;
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
    assign resp_err       = resp_hit && mem_resp_err;

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_req_valid  = req_valid;
    assign mem_wen        = req_wen;
    assign mem_addr       = req_addr;
    assign mem_wdata      = req_wdata;
    assign mem_wmask      = req_wmask;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected requests/responses, a negedge monitor pops and compares.
// Honours MEM_ARB_RR_EN to pick the expected contention winner after reset.
module tb_mem_arbiter;
    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct {
        logic        lsu;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

`ifdef MEM_ARB_RR_EN
    localparam bit LSU_WINS_FIRST = 1'b0;
`else
    localparam bit LSU_WINS_FIRST = 1'b1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid, mem_resp_err, resp_err;

    int    checks = 0;
    int    errors = 0;
    req_t  exp_req[$];
    resp_t exp_resp[$];
    req_t  mon_req;
    resp_t mon_resp;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .resp_err(resp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares every accepted downstream request and every upstream response against the queues.
    always @(negedge clock) begin
        if (ifu_resp_valid || lsu_resp_valid) begin
            check("resp_exclusive", 64'(ifu_resp_valid & lsu_resp_valid), 64'd0);
            if (exp_resp.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: got ifu=%0b lsu=%0b, expected none", ifu_resp_valid, lsu_resp_valid);
            end else begin
                mon_resp = exp_resp.pop_front();
                check("resp_owner_lsu", 64'(lsu_resp_valid), 64'(mon_resp.lsu));
                check("resp_rdata", mon_resp.lsu ? 64'(lsu_rdata) : 64'(ifu_rdata), 64'(mon_resp.rdata));
                check("resp_err", 64'(resp_err), 64'(mon_resp.err));
                check("resp_other_rdata_zero", mon_resp.lsu ? 64'(ifu_rdata) : 64'(lsu_rdata), 64'd0);
            end
        end else begin
            check("quiet_resp_outputs", {31'd0, resp_err, ifu_rdata | lsu_rdata}, 64'd0);
        end
        if (mem_req_valid && mem_req_ready) begin
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_mem_req: got addr 0x%0h, expected none", mem_addr);
            end else begin
                mon_req = exp_req.pop_front();
                check("mem_wen", 64'(mem_wen), 64'(mon_req.wen));
                check("mem_addr", 64'(mem_addr), 64'(mon_req.addr));
                check("mem_wmask", 64'(mem_wmask), 64'(mon_req.wmask));
                if (mon_req.wen) check("mem_wdata", 64'(mem_wdata), 64'(mon_req.wdata));
            end
        end
    end

    task automatic wait_grant(input logic lsu, input req_t r);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (lsu ? lsu_req_ready : ifu_req_ready) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout: got no ready for %s, expected ready within 20 cycles", lsu ? "lsu" : "ifu");
        end else begin
            check("grant_exclusive", 64'(lsu ? ifu_req_ready : lsu_req_ready), 64'd0);
            exp_req.push_back(r);
        end
        @(posedge clock); #1;
        if (lsu) lsu_req_valid = 1'b0;
        else     ifu_req_valid = 1'b0;
    endtask

    // Plays the downstream bridge from the first REQ cycle until the response beat has been taken.
    task automatic serve(input req_t r, input int ready_delay, input int resp_delay, input bit noise,
                         input logic lsu, input logic [31:0] rdata, input logic err);
        for (int i = 0; i < ready_delay; i++) begin
            if (noise) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = 32'hBAD0_BAD0;
            end
            @(negedge clock);
            check("hold_req_valid", 64'(mem_req_valid), 64'd1);
            check("hold_addr", 64'(mem_addr), 64'(r.addr));
            check("hold_wmask", 64'(mem_wmask), 64'(r.wmask));
            check("hold_wen", 64'(mem_wen), 64'(r.wen));
            if (r.wen) check("hold_wdata", 64'(mem_wdata), 64'(r.wdata));
            @(posedge clock); #1;
        end
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        mem_req_ready  = 1'b1;
        @(negedge clock);
        check("req_valid_at_accept", 64'(mem_req_valid), 64'd1);
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        for (int i = 0; i < resp_delay; i++) begin
            if (noise) mem_req_ready = 1'b1;
            @(negedge clock);
            check("resp_wait_req_valid", 64'(mem_req_valid), 64'd0);
            check("resp_wait_no_resp", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
            @(posedge clock); #1;
        end
        mem_req_ready = 1'b0;
        exp_resp.push_back('{lsu, rdata, err});
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        mem_resp_err   = err;
        @(negedge clock);
        check("resp_pulse", 64'(lsu ? lsu_resp_valid : ifu_resp_valid), 64'd1);
        @(posedge clock); #1;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        mem_rdata      = 32'h0;
    endtask

    task automatic apply_stimulus(input logic lsu, input logic wen, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wmask,
                                  input int ready_delay, input int resp_delay, input bit noise,
                                  input logic [31:0] rdata, input logic err);
        req_t r;
        r = '{lsu ? wen : 1'b0, addr, lsu ? wdata : 32'h0, lsu ? wmask : 4'hF};
        if (lsu) begin
            lsu_req_valid = 1'b1;
            lsu_wen       = wen;
            lsu_addr      = addr;
            lsu_wdata     = wdata;
            lsu_wmask     = wmask;
        end else begin
            ifu_req_valid = 1'b1;
            ifu_addr      = addr;
        end
        wait_grant(lsu, r);
        serve(r, ready_delay, resp_delay, noise, lsu, rdata, err);
    endtask

    task automatic contention(input bit lsu_first);
        req_t ri;
        req_t rl;
        ri = '{1'b0, 32'h8000_0100, 32'h0, 4'hF};
        rl = '{1'b0, 32'h0F00_0020, 32'h1234_5678, 4'b1100};
        ifu_req_valid = 1'b1;
        ifu_addr      = ri.addr;
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = rl.addr;
        lsu_wdata     = rl.wdata;
        lsu_wmask     = rl.wmask;
        @(negedge clock);
        check("contend_lsu_ready", 64'(lsu_req_ready), 64'(lsu_first));
        check("contend_ifu_ready", 64'(ifu_req_ready), 64'(!lsu_first));
        exp_req.push_back(lsu_first ? rl : ri);
        @(posedge clock); #1;
        if (lsu_first) lsu_req_valid = 1'b0;
        else           ifu_req_valid = 1'b0;
        serve(lsu_first ? rl : ri, 1, 0, 1'b0, lsu_first, 32'h1111_0001, 1'b0);
        @(negedge clock);
        check("loser_granted_next_idle", 64'(lsu_first ? ifu_req_ready : lsu_req_ready), 64'd1);
        exp_req.push_back(lsu_first ? ri : rl);
        @(posedge clock); #1;
        if (lsu_first) ifu_req_valid = 1'b0;
        else           lsu_req_valid = 1'b0;
        serve(lsu_first ? ri : rl, 0, 0, 1'b0, !lsu_first, 32'h2222_0002, 1'b0);
    endtask

    initial begin
        req_t r;
        reset          = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h0;
        lsu_req_valid  = 1'b1;
        lsu_wen        = 1'b0;
        lsu_addr       = 32'h0;
        lsu_wdata      = 32'h0;
        lsu_wmask      = 4'h0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_FFFF;
        mem_resp_err   = 1'b1;
        #12;
        check("reset_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
        check("reset_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
        check("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("reset_resp_valids", 64'(ifu_resp_valid | lsu_resp_valid | resp_err), 64'd0);
        check("reset_mem_fields", {mem_wen, mem_wmask, mem_addr}, 64'd0);
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        mem_resp_err   = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        contention(LSU_WINS_FIRST);
        apply_stimulus(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 1'b0, 32'h0000_0413, 1'b0);
        apply_stimulus(1'b1, 1'b1, 32'h0F00_0010, 32'hDEAD_BEEF, 4'b0011, 3, 0, 1'b0, 32'h5A5A_5A5A, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'hA000_0000, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0000_0000, 1'b1);

        // Stray response beats while idle must not produce a response or leave IDLE.
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_F00D;
        mem_resp_err   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("idle_stray_no_resp", 64'(ifu_resp_valid | lsu_resp_valid | resp_err), 64'd0);
            check("idle_stray_no_req", 64'(mem_req_valid), 64'd0);
            @(posedge clock); #1;
        end
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        mem_resp_err   = 1'b0;
        apply_stimulus(1'b1, 1'b0, 32'h0F00_0040, 32'h0, 4'b0001, 2, 2, 1'b1, 32'h0000_00AB, 1'b0);

        // Drop reset while a read waits in RESP, with a response beat arriving at the same moment.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0200;
        r = '{1'b0, 32'h8000_0200, 32'h0, 4'hF};
        wait_grant(1'b0, r);
        mem_req_ready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        mem_req_ready = 1'b0;
        @(negedge clock);
        check("midop_in_resp", 64'(mem_req_valid), 64'd0);
        #2;
        ifu_req_valid  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_err   = 1'b1;
        mem_rdata      = 32'h7777_7777;
        reset          = 1'b0;
        #1;
        check("midop_resp_valids", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
        check("midop_rdata", 64'(ifu_rdata | lsu_rdata), 64'd0);
        check("midop_resp_err", 64'(resp_err), 64'd0);
        check("midop_ifu_ready", 64'(ifu_req_ready), 64'd0);
        check("midop_mem_fields", {mem_req_valid, mem_wmask, mem_addr}, 64'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        mem_rdata      = 32'h0;
        reset          = 1'b1;
        @(posedge clock); #1;

        contention(LSU_WINS_FIRST);
        apply_stimulus(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1, 1, 1'b0, 32'h0041_0113, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("exp_req_drained", 64'(exp_req.size()), 64'd0);
        check("exp_resp_drained", 64'(exp_resp.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, expected earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester memory arbiter between the core's fetch path (IFU, read-only) and its load/store path (LSU, read/write).
- Output is one simple valid/ready request channel plus a response channel, feeding the core's single AXI master bridge.
- At most one transaction is outstanding at a time. Downstream request fields are registered, so the bridge sees stable signals.
- Every instruction's fetch and memory access is sequenced through this block.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Mask width is DATA_W/8.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_resp_valid  out  1  IFU read data valid (one-cycle pulse).
- ifu_rdata  out  DATA_W  IFU read data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wmask  in  DATA_W/8  byte mask (used for both read and write).
- lsu_resp_valid  out  1  LSU response (read data or write ack), one-cycle pulse.
- lsu_rdata  out  DATA_W  LSU read data.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream accepts the request.
- mem_wen  out  1  downstream write flag.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_wmask  out  DATA_W/8  downstream byte mask.
- mem_resp_valid  in  1  downstream response valid.
- mem_rdata  in  DATA_W  downstream read data.
- mem_resp_err  in  1  downstream error response (SLVERR/DECERR).
- resp_err  out  1  error flag, qualified by ifu_resp_valid or lsu_resp_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; owner=IFU; all registered request fields 0.
  - All outputs 0, including both req_ready outputs.
  - Any in-flight transaction is dropped; the downstream bridge is reset by the same signal.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Grant is computed combinationally from the two valids.
  - The granted requester gets req_ready=1 in the same cycle. Only one req_ready is ever high.
  - On grant, latch into registers: requester addr/wdata/wmask/wen (IFU forces wen=0, wmask=all-ones). Set owner to the granted requester.
  - Next state is REQ.
  - With no request, stay in IDLE.
- REQ:
  - mem_req_valid=1; fields come from registers and stay stable.
  - On mem_req_ready=1, go to RESP and drop mem_req_valid the next cycle.
  - Accept-to-mem_req_valid latency is 1 cycle.
- RESP:
  - Wait for mem_resp_valid.
  - In that cycle, combinationally drive owner's resp_valid=1, owner's rdata=mem_rdata, and resp_err=mem_resp_err. Next state is IDLE.
  - The non-owner's resp_valid stays 0; both rdata outputs are 0 when not valid.
  - Requesters must consume the response; there is no response back-pressure.
- Back-to-back requests: a new grant may occur in the IDLE cycle right after the response. Minimum turnaround is 3 cycles per transaction with zero downstream wait.
- Default grant policy is fixed priority, LSU over IFU. When both valids are high in IDLE, LSU wins; IFU req_ready=0 and IFU must hold its request.
- Responses never overlap:
  - mem_resp_valid in IDLE or REQ is ignored; no resp_valid is generated.
  - mem_req_ready outside REQ is ignored.
- Upstream requests must stay stable while valid and not yet accepted. The arbiter does not sample them outside the grant cycle.
- Write ack: for an LSU write, lsu_resp_valid pulses with lsu_rdata=mem_rdata; the value is don't-care to the LSU.

Optional Feature:
- Macro MEM_ARB_RR_EN.
  - Defined: round-robin grant. A 1-bit last_owner register updates on each grant. When both request, the requester that did not win last time wins. last_owner resets to LSU, so IFU wins the first contention.
  - Undefined: fixed LSU-over-IFU priority as above; no last_owner register.

Test Plan:
- IFU read alone: ifu_addr=0x80000000, mem_req_ready=1 immediately, mem_resp_valid 2 cycles later with mem_rdata=0x00000413 -> mem_req_valid 1 cycle after accept with mem_wen=0 and mem_wmask=4'hF; ifu_resp_valid pulses once with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
- LSU write: lsu_wen=1, lsu_addr=0x0F000010, lsu_wdata=0xDEADBEEF, lsu_wmask=4'b0011, mem_req_ready held 0 for 3 cycles -> mem_req_valid stays 1 with stable fields for 4 cycles; lsu_resp_valid pulses on mem_resp_valid.
- Contention: ifu_req_valid and lsu_req_valid both 1 in IDLE -> LSU granted first and IFU granted in the IDLE after LSU's response. With MEM_ARB_RR_EN, IFU is granted first after reset.
- Error path: mem_resp_err=1 on an IFU read to 0xA0000000 -> ifu_resp_valid=1 and resp_err=1 in the same cycle.
- Spurious inputs: mem_resp_valid=1 while in IDLE, mem_req_ready=1 while in RESP -> no resp_valid, no state change.
- Reset mid-operation: reset=0 during RESP -> all outputs 0 immediately (asynchronous). After release, state is IDLE and a new IFU request is granted normally.
